// File: rtl/i2c_reg_slave.sv
// I2C register target: decodes {addr, sub-addr, data...} writes and sub-addressed reads
// into a byte-wide register bus in the iCLK domain, with auto-increment and repeated START.
module i2c_reg_slave (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic       oWR_EN,
    output logic [7:0] oWR_ADDR,
    output logic [7:0] oWR_DATA,
    output logic [7:0] oRD_ADDR,
    input  logic [7:0] iRD_DATA,
    output logic       oBUSY,
    output logic       oSTOP
);
    localparam logic [6:0] SLAVE_ADDR = 7'h39;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_ADDR   = 4'd1;
    localparam logic [3:0] S_ACK_A  = 4'd2;
    localparam logic [3:0] S_SUB    = 4'd3;
    localparam logic [3:0] S_ACK_S  = 4'd4;
    localparam logic [3:0] S_WDATA  = 4'd5;
    localparam logic [3:0] S_ACK_W  = 4'd6;
    localparam logic [3:0] S_RDATA  = 4'd7;
    localparam logic [3:0] S_MACK   = 4'd8;
    localparam logic [3:0] S_IGNORE = 4'd9;

    logic       r_scl_s1, r_scl_s2, r_scl_d;
    logic       r_sda_s1, r_sda_s2, r_sda_d;
    logic [3:0] r_state;
    logic [3:0] r_bitcnt;
    logic [6:0] r_shift;
    logic [7:0] r_ptr;
    logic       r_sda_oe;
    logic       r_ack_ph;
    logic       r_rw;
    logic       r_wr_en;
    logic [7:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic       r_busy;
    logic       r_stop;

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte;

    // Synchronizers reset to the idle-bus level so reset release creates no false events.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= I2C_SCLK;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= I2C_SDAT;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_byte     = {r_shift, r_sda_s2};

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state   <= S_IDLE;
            r_bitcnt  <= 4'd0;
            r_shift   <= 7'd0;
            r_ptr     <= 8'd0;
            r_sda_oe  <= 1'b0;
            r_ack_ph  <= 1'b0;
            r_rw      <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 8'd0;
            r_wr_data <= 8'd0;
            r_busy    <= 1'b0;
            r_stop    <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_stop  <= 1'b0;
            if (w_stop) begin
                r_state  <= S_IDLE;
                r_sda_oe <= 1'b0;
                r_bitcnt <= 4'd0;
                r_busy   <= 1'b0;
                r_stop   <= 1'b1;
            end else if (w_start) begin
                r_state  <= S_ADDR;
                r_sda_oe <= 1'b0;
                r_bitcnt <= 4'd0;
                r_ack_ph <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_SUB, S_WDATA: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte[6:0];
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (r_bitcnt == 4'd7) begin
                                r_bitcnt <= 4'd0;
                                r_ack_ph <= 1'b0;
                                if (r_state == S_ADDR) begin
                                    if (w_byte[7:1] == SLAVE_ADDR) begin
                                        r_rw    <= w_byte[0];
                                        r_busy  <= 1'b1;
                                        r_state <= S_ACK_A;
                                    end else begin
                                        r_state <= S_IGNORE;
                                    end
                                end else if (r_state == S_SUB) begin
                                    r_ptr   <= w_byte;
                                    r_state <= S_ACK_S;
                                end else begin
                                    r_wr_en   <= 1'b1;
                                    r_wr_addr <= r_ptr;
                                    r_wr_data <= w_byte;
                                    r_ptr     <= r_ptr + 8'd1;
                                    r_state   <= S_ACK_W;
                                end
                            end
                        end
                    end
                    // First SCL fall pulls SDA low, second fall releases it and moves on.
                    S_ACK_A, S_ACK_S, S_ACK_W: begin
                        if (w_scl_fall) begin
                            if (!r_ack_ph) begin
                                r_sda_oe <= 1'b1;
                                r_ack_ph <= 1'b1;
                            end else begin
                                r_ack_ph <= 1'b0;
                                if (r_state == S_ACK_A && r_rw) begin
                                    r_shift  <= iRD_DATA[6:0];
                                    r_sda_oe <= ~iRD_DATA[7];
                                    r_state  <= S_RDATA;
                                end else begin
                                    r_sda_oe <= 1'b0;
                                    r_state  <= (r_state == S_ACK_A) ? S_SUB : S_WDATA;
                                end
                            end
                        end
                    end
                    S_RDATA: begin
                        if (w_scl_rise) begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bitcnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                                r_bitcnt <= 4'd0;
                                r_ack_ph <= 1'b0;
                                r_state  <= S_MACK;
                            end else begin
                                r_sda_oe <= ~r_shift[6];
                                r_shift  <= {r_shift[5:0], 1'b0};
                            end
                        end
                    end
                    // r_ack_ph marks a received master ACK; reload waits for the next fall.
                    S_MACK: begin
                        if (w_scl_rise) begin
                            if (r_sda_s2) begin
                                r_state <= S_IGNORE;
                            end else begin
                                r_ptr    <= r_ptr + 8'd1;
                                r_ack_ph <= 1'b1;
                            end
                        end else if (w_scl_fall && r_ack_ph) begin
                            r_ack_ph <= 1'b0;
                            r_shift  <= iRD_DATA[6:0];
                            r_sda_oe <= ~iRD_DATA[7];
                            r_state  <= S_RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign I2C_SDAT = r_sda_oe ? 1'b0 : 1'bz;
    assign oWR_EN   = r_wr_en;
    assign oWR_ADDR = r_wr_addr;
    assign oWR_DATA = r_wr_data;
    assign oRD_ADDR = r_ptr;
    assign oBUSY    = r_busy;
    assign oSTOP    = r_stop;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: bit-banged I2C master, write/read scoreboards, per-scenario tasks.
module tb_i2c_reg_slave;
    localparam int Q = 5;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic       r_m_scl = 1'b1;
    logic       r_m_sda = 1'b1;
    wire        w_sda;
    logic       oWR_EN;
    logic [7:0] oWR_ADDR;
    logic [7:0] oWR_DATA;
    logic [7:0] oRD_ADDR;
    logic [7:0] w_rd_data;
    logic       oBUSY;
    logic       oSTOP;

    int total = 0;
    int bad = 0;
    int stop_cnt = 0;
    int low_cnt = 0;
    int busy_cnt = 0;
    logic [15:0] exp_wr[$];
    logic [15:0] obs_wr[$];
    logic [7:0]  exp_rd[$];

    always #5 iCLK = ~iCLK;

    pullup (w_sda);
    assign w_sda = r_m_sda ? 1'bz : 1'b0;
    // Register bank model: data at each address is address + 0x10.
    assign w_rd_data = oRD_ADDR + 8'h10;

    i2c_reg_slave dut (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .I2C_SCLK (r_m_scl),
        .I2C_SDAT (w_sda),
        .oWR_EN   (oWR_EN),
        .oWR_ADDR (oWR_ADDR),
        .oWR_DATA (oWR_DATA),
        .oRD_ADDR (oRD_ADDR),
        .iRD_DATA (w_rd_data),
        .oBUSY    (oBUSY),
        .oSTOP    (oSTOP)
    );

    always @(negedge iCLK) begin
        if (oWR_EN) obs_wr.push_back({oWR_ADDR, oWR_DATA});
        if (oSTOP) stop_cnt++;
        if (oBUSY) busy_cnt++;
        if (r_m_sda && w_sda === 1'b0) low_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge iCLK);
    endtask

    task automatic i2c_start();
        r_m_sda = 1'b1; wait_clk(Q);
        r_m_scl = 1'b1; wait_clk(Q);
        r_m_sda = 1'b0; wait_clk(Q);
        r_m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        r_m_sda = 1'b0; wait_clk(Q);
        r_m_scl = 1'b1; wait_clk(Q);
        r_m_sda = 1'b1; wait_clk(Q);
    endtask

    task automatic wr_bit(input logic b);
        r_m_sda = b;    wait_clk(Q);
        r_m_scl = 1'b1; wait_clk(2 * Q);
        r_m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic rd_bit(output logic b);
        r_m_sda = 1'b1; wait_clk(Q);
        r_m_scl = 1'b1; wait_clk(Q);
        b = w_sda;      wait_clk(Q);
        r_m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wr_bit(d[i]);
        rd_bit(ack);
    endtask

    task automatic rd_byte(output logic [7:0] d, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rd_bit(b);
            d[i] = b;
        end
        wr_bit(mack);
    endtask

    task automatic test_reset();
        iRST_N = 1'b0;
        wait_clk(4);
        total += 7;
        if (oWR_EN !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b want=0", oWR_EN); end
        if (oWR_ADDR !== 8'h00) begin bad++; $display("FAIL reset_wr_addr got=%h want=00", oWR_ADDR); end
        if (oWR_DATA !== 8'h00) begin bad++; $display("FAIL reset_wr_data got=%h want=00", oWR_DATA); end
        if (oRD_ADDR !== 8'h00) begin bad++; $display("FAIL reset_rd_addr got=%h want=00", oRD_ADDR); end
        if (oBUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", oBUSY); end
        if (oSTOP !== 1'b0) begin bad++; $display("FAIL reset_stop got=%b want=0", oSTOP); end
        if (w_sda !== 1'b1) begin bad++; $display("FAIL reset_sda got=%b want=1", w_sda); end
        iRST_N = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_single_write();
        logic a0, a1, a2;
        int s0;
        logic [15:0] o, e;
        s0 = stop_cnt;
        exp_wr.push_back({8'h98, 8'h03});
        i2c_start();
        wr_byte(8'h72, a0);
        wr_byte(8'h98, a1);
        wr_byte(8'h03, a2);
        total += 4;
        if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL single_acks got=%b want=000", {a0, a1, a2}); end
        if (oBUSY !== 1'b1) begin bad++; $display("FAIL single_busy_mid got=%b want=1", oBUSY); end
        i2c_stop();
        wait_clk(10);
        if (stop_cnt - s0 !== 1) begin bad++; $display("FAIL single_stop_pulses got=%0d want=1", stop_cnt - s0); end
        if (oBUSY !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b want=0", oBUSY); end
        while (obs_wr.size() > 0 || exp_wr.size() > 0) begin
            total++;
            if (obs_wr.size() == 0 || exp_wr.size() == 0) begin
                bad++;
                $display("FAIL single_strobe_count got=%0d want=%0d", obs_wr.size(), exp_wr.size());
                obs_wr.delete(); exp_wr.delete();
            end else begin
                o = obs_wr.pop_front(); e = exp_wr.pop_front();
                if (o !== e) begin bad++; $display("FAIL single_strobe got=%h want=%h", o, e); end
            end
        end
    endtask

    task automatic test_burst_wrap();
        logic [4:0] acks;
        logic [15:0] o, e;
        exp_wr.push_back({8'hFE, 8'h11});
        exp_wr.push_back({8'hFF, 8'h22});
        exp_wr.push_back({8'h00, 8'h33});
        i2c_start();
        wr_byte(8'h72, acks[4]);
        wr_byte(8'hFE, acks[3]);
        wr_byte(8'h11, acks[2]);
        wr_byte(8'h22, acks[1]);
        wr_byte(8'h33, acks[0]);
        i2c_stop();
        wait_clk(10);
        total += 2;
        if (acks !== 5'b0) begin bad++; $display("FAIL burst_acks got=%b want=00000", acks); end
        if (oRD_ADDR !== 8'h01) begin bad++; $display("FAIL burst_ptr got=%h want=01", oRD_ADDR); end
        while (obs_wr.size() > 0 || exp_wr.size() > 0) begin
            total++;
            if (obs_wr.size() == 0 || exp_wr.size() == 0) begin
                bad++;
                $display("FAIL burst_strobe_count got=%0d want=%0d", obs_wr.size(), exp_wr.size());
                obs_wr.delete(); exp_wr.delete();
            end else begin
                o = obs_wr.pop_front(); e = exp_wr.pop_front();
                if (o !== e) begin bad++; $display("FAIL burst_strobe got=%h want=%h", o, e); end
            end
        end
    endtask

    task automatic test_mismatch();
        logic a0, a1, a2;
        int l0, b0;
        l0 = low_cnt;
        b0 = busy_cnt;
        i2c_start();
        wr_byte(8'h74, a0);
        wr_byte(8'h98, a1);
        wr_byte(8'h03, a2);
        i2c_stop();
        wait_clk(10);
        total += 4;
        if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL mismatch_acks got=%b want=111", {a0, a1, a2}); end
        if (low_cnt - l0 !== 0) begin bad++; $display("FAIL mismatch_sda_low got=%0d want=0", low_cnt - l0); end
        if (busy_cnt - b0 !== 0) begin bad++; $display("FAIL mismatch_busy got=%0d want=0", busy_cnt - b0); end
        if (obs_wr.size() !== 0) begin bad++; $display("FAIL mismatch_strobes got=%0d want=0", obs_wr.size()); end
        obs_wr.delete();
    endtask

    task automatic test_read_sr();
        logic a0, a1, a2;
        logic [7:0] d, e;
        i2c_start();
        wr_byte(8'h72, a0);
        wr_byte(8'h41, a1);
        exp_rd.push_back(8'h51);
        exp_rd.push_back(8'h52);
        i2c_start();
        wr_byte(8'h73, a2);
        total += 1;
        if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL read_acks got=%b want=000", {a0, a1, a2}); end
        for (int k = 0; k < 2; k++) begin
            rd_byte(d, (k == 1));
            e = exp_rd.pop_front();
            total++;
            if (d !== e) begin bad++; $display("FAIL read_byte%0d got=%h want=%h", k, d, e); end
        end
        wait_clk(2);
        total += 2;
        if (w_sda !== 1'b1) begin bad++; $display("FAIL read_release got=%b want=1", w_sda); end
        if (oRD_ADDR !== 8'h42) begin bad++; $display("FAIL read_ptr got=%h want=42", oRD_ADDR); end
        i2c_stop();
        wait_clk(10);
    endtask

    task automatic test_stop_mid_byte();
        logic a0, a1;
        int s0;
        s0 = stop_cnt;
        i2c_start();
        wr_byte(8'h72, a0);
        wr_byte(8'h33, a1);
        wr_bit(1'b1);
        wr_bit(1'b0);
        wr_bit(1'b1);
        i2c_stop();
        wait_clk(10);
        total += 4;
        if ({a0, a1} !== 2'b00) begin bad++; $display("FAIL midstop_acks got=%b want=00", {a0, a1}); end
        if (obs_wr.size() !== 0) begin bad++; $display("FAIL midstop_strobes got=%0d want=0", obs_wr.size()); end
        if (stop_cnt - s0 !== 1) begin bad++; $display("FAIL midstop_pulses got=%0d want=1", stop_cnt - s0); end
        if (oBUSY !== 1'b0) begin bad++; $display("FAIL midstop_busy got=%b want=0", oBUSY); end
        obs_wr.delete();
    endtask

    task automatic test_reset_mid_read();
        logic a0, a1, a2, b;
        logic [2:0] bits;
        logic [15:0] o, e;
        i2c_start();
        wr_byte(8'h72, a0);
        wr_byte(8'h50, a1);
        i2c_start();
        wr_byte(8'h73, a2);
        // Byte at 0x50 is 0x60: the fourth bit is 0, so SDA is held low at reset time.
        for (int i = 2; i >= 0; i--) begin
            rd_bit(b);
            bits[i] = b;
        end
        total += 3;
        if (bits !== 3'b011) begin bad++; $display("FAIL midrst_bits got=%b want=011", bits); end
        if (w_sda !== 1'b0) begin bad++; $display("FAIL midrst_drive got=%b want=0", w_sda); end
        #2 iRST_N = 1'b0;
        #1;
        if (w_sda !== 1'b1) begin bad++; $display("FAIL midrst_release got=%b want=1", w_sda); end
        total += 4;
        if (oWR_EN !== 1'b0) begin bad++; $display("FAIL midrst_wr_en got=%b want=0", oWR_EN); end
        if (oRD_ADDR !== 8'h00) begin bad++; $display("FAIL midrst_ptr got=%h want=00", oRD_ADDR); end
        if (oBUSY !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", oBUSY); end
        if (oWR_ADDR !== 8'h00 || oWR_DATA !== 8'h00) begin
            bad++; $display("FAIL midrst_wr_bus got=%h%h want=0000", oWR_ADDR, oWR_DATA);
        end
        wait_clk(3);
        iRST_N = 1'b1;
        wait_clk(3);
        exp_wr.push_back({8'h10, 8'hAB});
        i2c_start();
        wr_byte(8'h72, a0);
        wr_byte(8'h10, a1);
        wr_byte(8'hAB, a2);
        i2c_stop();
        wait_clk(10);
        total++;
        if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL postrst_acks got=%b want=000", {a0, a1, a2}); end
        while (obs_wr.size() > 0 || exp_wr.size() > 0) begin
            total++;
            if (obs_wr.size() == 0 || exp_wr.size() == 0) begin
                bad++;
                $display("FAIL postrst_strobe_count got=%0d want=%0d", obs_wr.size(), exp_wr.size());
                obs_wr.delete(); exp_wr.delete();
            end else begin
                o = obs_wr.pop_front(); e = exp_wr.pop_front();
                if (o !== e) begin bad++; $display("FAIL postrst_strobe got=%h want=%h", o, e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_wrap();
        test_mismatch();
        test_read_sr();
        test_stop_mid_byte();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
